comp_mux_unit: RTL and testbench

Magnitude comparator built from 2:1 multiplexer cells: compares operands `a` and `b` and reports greater / lesser / equal. Combinational result outputs give zero-latency flags, and a registered copy, with a valid strobe, feeds synchronous downstream logic. It is a leaf utility block in the datapath.

---
 rtl/comp_mux_unit.sv | 82 ++++++++
 tb/tb_comp_mux_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/comp_mux_unit.sv
// Magnitude comparator built from 2:1 mux cells, cascaded MSB to LSB.
// Zero-latency greater/lesser/equal flags plus a registered copy with a valid strobe.
module comp_mux_unit #(
  parameter int WIDTH  = 1,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic             greater,
  output logic             lesser,
  output logic             equal,
  output logic             greater_q,
  output logic             lesser_q,
  output logic             equal_q,
  output logic             valid_q
);

  logic [WIDTH-1:0] w_g_cell;
  logic [WIDTH-1:0] w_l_cell;
  logic [WIDTH-1:0] w_e_cell;
  logic [WIDTH-1:0] w_gt;
  logic [WIDTH-1:0] w_lt;
  logic [WIDTH-1:0] w_eq;

  logic r_greater_q;
  logic r_lesser_q;
  logic r_equal_q;
  logic r_valid_q;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      // In two's complement a set MSB means negative, so the MSB cell's g/l swap.
      if ((gi == WIDTH - 1) && (SIGNED != 0)) begin : g_signed_msb
        assign w_g_cell[gi] = a[gi] ? 1'b0   : b[gi];
        assign w_l_cell[gi] = a[gi] ? ~b[gi] : 1'b0;
      end else begin : g_plain
        assign w_g_cell[gi] = a[gi] ? ~b[gi] : 1'b0;
        assign w_l_cell[gi] = a[gi] ? 1'b0   : b[gi];
      end
      assign w_e_cell[gi] = a[gi] ? b[gi] : ~b[gi];

      if (gi == WIDTH - 1) begin : g_head
        assign w_gt[gi] = w_g_cell[gi];
        assign w_lt[gi] = w_l_cell[gi];
        assign w_eq[gi] = w_e_cell[gi];
      end else begin : g_chain
        // A lower bit only decides while every higher bit is still equal.
        assign w_gt[gi] = w_eq[gi+1] ? w_g_cell[gi] : w_gt[gi+1];
        assign w_lt[gi] = w_eq[gi+1] ? w_l_cell[gi] : w_lt[gi+1];
        assign w_eq[gi] = w_eq[gi+1] ? w_e_cell[gi] : 1'b0;
      end
    end
  endgenerate

  assign greater = w_gt[0];
  assign lesser  = w_lt[0];
  assign equal   = w_eq[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_greater_q <= 1'b0;
      r_lesser_q  <= 1'b0;
      r_equal_q   <= 1'b0;
      r_valid_q   <= 1'b0;
    end else if (en) begin
      r_greater_q <= w_gt[0];
      r_lesser_q  <= w_lt[0];
      r_equal_q   <= w_eq[0];
      r_valid_q   <= 1'b1;
    end
  end

  assign greater_q = r_greater_q;
  assign lesser_q  = r_lesser_q;
  assign equal_q   = r_equal_q;
  assign valid_q   = r_valid_q;

endmodule

// File: tb/tb_comp_mux_unit.sv
// Directed self-checking bench for comp_mux_unit: 1-, 4- and 8-bit instances,
// unsigned and signed, combinational flags and the registered path.
module tb_comp_mux_unit;

  logic clk;
  logic clk_run;
  logic rst_n;
  logic en;

  logic       a1, b1;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;

  logic g1, l1, e1, g1q, l1q, e1q, v1q;
  logic g8u, l8u, e8u, g8uq, l8uq, e8uq, v8uq;
  logic g8s, l8s, e8s, g8sq, l8sq, e8sq, v8sq;
  logic g4u, l4u, e4u, g4uq, l4uq, e4uq, v4uq;
  logic g4s, l4s, e4s, g4sq, l4sq, e4sq, v4sq;

  int checks;
  int failures;

  comp_mux_unit #(.WIDTH(1), .SIGNED(0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .en(en),
    .greater(g1), .lesser(l1), .equal(e1),
    .greater_q(g1q), .lesser_q(l1q), .equal_q(e1q), .valid_q(v1q)
  );

  comp_mux_unit #(.WIDTH(8), .SIGNED(0)) u_w8u (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .en(en),
    .greater(g8u), .lesser(l8u), .equal(e8u),
    .greater_q(g8uq), .lesser_q(l8uq), .equal_q(e8uq), .valid_q(v8uq)
  );

  comp_mux_unit #(.WIDTH(8), .SIGNED(1)) u_w8s (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .en(en),
    .greater(g8s), .lesser(l8s), .equal(e8s),
    .greater_q(g8sq), .lesser_q(l8sq), .equal_q(e8sq), .valid_q(v8sq)
  );

  comp_mux_unit #(.WIDTH(4), .SIGNED(0)) u_w4u (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .en(en),
    .greater(g4u), .lesser(l4u), .equal(e4u),
    .greater_q(g4uq), .lesser_q(l4uq), .equal_q(e4uq), .valid_q(v4uq)
  );

  comp_mux_unit #(.WIDTH(4), .SIGNED(1)) u_w4s (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .en(en),
    .greater(g4s), .lesser(l4s), .equal(e4s),
    .greater_q(g4sq), .lesser_q(l4sq), .equal_q(e4sq), .valid_q(v4sq)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int sa;
    int sb;
    logic [2:0] exp_flags;

    checks   = 0;
    failures = 0;
    clk_run  = 1'b0;
    rst_n    = 1'b0;
    en       = 1'b0;
    a1 = 1'b0; b1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00;
    a4 = 4'h0; b4 = 4'h0;

    // WIDTH=1 truth table, no clock running, flags ordered {greater,lesser,equal}
    #10; chk("w1_00", {5'd0, g1, l1, e1}, 8'b001);
    a1 = 1'b0; b1 = 1'b1;
    #10; chk("w1_01", {5'd0, g1, l1, e1}, 8'b010);
    a1 = 1'b1; b1 = 1'b0;
    #10; chk("w1_10", {5'd0, g1, l1, e1}, 8'b100);
    a1 = 1'b1; b1 = 1'b1;
    #10; chk("w1_11", {5'd0, g1, l1, e1}, 8'b001);

    // 8-bit unsigned and signed directed vectors
    a8 = 8'h80; b8 = 8'h7F;
    #10; chk("u8_80_7f", {5'd0, g8u, l8u, e8u}, 8'b100);
    chk("s8_80_7f", {5'd0, g8s, l8s, e8s}, 8'b010);
    a8 = 8'h3C; b8 = 8'h3C;
    #10; chk("u8_3c_3c", {5'd0, g8u, l8u, e8u}, 8'b001);
    chk("s8_3c_3c", {5'd0, g8s, l8s, e8s}, 8'b001);
    a8 = 8'h00; b8 = 8'hFF;
    #10; chk("u8_00_ff", {5'd0, g8u, l8u, e8u}, 8'b010);
    chk("s8_00_ff", {5'd0, g8s, l8s, e8s}, 8'b100);
    a8 = 8'hFF; b8 = 8'hFE;
    #10; chk("s8_ff_fe", {5'd0, g8s, l8s, e8s}, 8'b100);
    chk("u8_ff_fe", {5'd0, g8u, l8u, e8u}, 8'b100);
    a8 = 8'h01; b8 = 8'h81;
    #10; chk("u8_01_81", {5'd0, g8u, l8u, e8u}, 8'b010);
    chk("s8_01_81", {5'd0, g8s, l8s, e8s}, 8'b100);

    // Exhaustive 4-bit, both signedness settings, against an integer reference
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a4 = i[3:0];
        b4 = j[3:0];
        #1;
        exp_flags = {(i > j), (i < j), (i == j)};
        chk($sformatf("u4_%0d_%0d", i, j), {5'd0, g4u, l4u, e4u}, {5'd0, exp_flags});
        sa = (i >= 8) ? i - 16 : i;
        sb = (j >= 8) ? j - 16 : j;
        exp_flags = {(sa > sb), (sa < sb), (sa == sb)};
        chk($sformatf("s4_%0d_%0d", i, j), {5'd0, g4s, l4s, e4s}, {5'd0, exp_flags});
      end
    end

    // Registered outputs held in reset, {greater_q,lesser_q,equal_q,valid_q}
    chk("rst_q_u8", {4'd0, g8uq, l8uq, e8uq, v8uq}, 8'h0);
    chk("rst_q_s8", {4'd0, g8sq, l8sq, e8sq, v8sq}, 8'h0);

    // Release reset and capture a=5, b=3
    clk_run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    a8 = 8'd5; b8 = 8'd3; en = 1'b1;
    @(posedge clk); #1;
    chk("cap_gt", {4'd0, g8uq, l8uq, e8uq, v8uq}, 8'b1001);

    // Hold with en low even though the compare result changes
    en = 1'b0; a8 = 8'd1;
    #1; chk("comb_lt_hold", {5'd0, g8u, l8u, e8u}, 8'b010);
    @(posedge clk); #1;
    chk("hold_gt", {4'd0, g8uq, l8uq, e8uq, v8uq}, 8'b1001);

    // Asynchronous reset between edges; combinational flags keep tracking
    #2 rst_n = 1'b0;
    #1; chk("async_rst_q", {4'd0, g8uq, l8uq, e8uq, v8uq}, 8'h0);
    chk("async_rst_comb", {5'd0, g8u, l8u, e8u}, 8'b010);
    a8 = 8'd9;
    #1; chk("rst_comb_track", {5'd0, g8u, l8u, e8u}, 8'b100);
    @(posedge clk); #1;
    chk("rst_held_q", {4'd0, g8uq, l8uq, e8uq, v8uq}, 8'h0);

    // First capture after release, then an equal capture
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    chk("recap_gt", {4'd0, g8uq, l8uq, e8uq, v8uq}, 8'b1001);
    a8 = 8'd3;
    @(posedge clk); #1;
    chk("cap_eq", {4'd0, g8uq, l8uq, e8uq, v8uq}, 8'b0011);
    a8 = 8'hF0; b8 = 8'h10;
    @(posedge clk); #1;
    chk("cap_s8_lt", {4'd0, g8sq, l8sq, e8sq, v8sq}, 8'b0101);
    chk("cap_u8_gt", {4'd0, g8uq, l8uq, e8uq, v8uq}, 8'b1001);

    clk_run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
